sram_access_ctrl: RTL and testbench
===================================

# sram_access_ctrl

Digital access sequencer for the mixed-signal SRAM array: accepts one read or write request at a time and generates the ordered, non-overlapping analog control phases (bitline precharge, wordline, write drive, sense-amp enable). These phases gate the array's transistor-level devices. Sits between the digital request port and the analog array wrapper, which level-converts each enable to VDD/VSS (1.5 V / 0.0 V) gate drive.

## Interface
- ADDR_W, 4, row address width; ROWS = 2**ADDR_W wordlines
- DATA_W, 8, bits per row
- PRE_CYC, 2, precharge phase length in clocks (≥1)
- WL_CYC, 3, read wordline phase length in clocks (≥1)
- WR_CYC, 3, write wordline+drive phase length in clocks (≥1)
- SAE_CYC, 1, sense-amp enable phase length in clocks (≥1)

Ports:
- clk  in  1  array control clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  row address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  operation complete; read data valid
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_W  captured read data (write: unchanged)
- pre_n  out  1  bitline precharge, active-low
- wl  out  ROWS  one-hot wordline enables
- wr_en  out  1  write driver enable
- bl_data  out  DATA_W  write-driver data
- sae  out  1  sense-amp enable
- sa_out  in  DATA_W  sense-amp outputs, valid while sae=1

## Operation
- States: IDLE, PRE, GAP, WL, SENSE, RESP. Phase down-counter sized $clog2(max *_CYC + 1); any *_CYC = 0 is an elaboration error.
- IDLE: pre_n=0 (bitlines held precharged), req_ready=1. On req_valid&&req_ready, latch we/addr/wdata; go PRE.
- PRE: pre_n=0 for PRE_CYC cycles → GAP.
- GAP: exactly one cycle, pre_n=1, wl=0, wr_en=0, sae=0 (break-before-make) → WL.
- WL: wl[addr]=1, pre_n=1. Write: wr_en=1, bl_data=latched wdata, length WR_CYC → RESP. Read: wr_en=0, length WL_CYC → SENSE.
- SENSE: wl=0, sae=1 for SAE_CYC cycles; sa_out captured into rsp_rdata on the clock edge ending the last SENSE cycle → RESP.
- RESP: rsp_valid=1, pre_n=0, all other enables low; hold until rsp_ready=1, then → IDLE (rsp_valid drops same edge).
- bl_data returns to 0 whenever wr_en=0.
- Invariants (must hold every cycle): popcount(wl) ≤ 1; never (pre_n=0 and any wl=1); never (sae=1 and any wl=1); never (wr_en=1 and sae=1).
- Requests arriving while req_ready=0 are ignored (not queued); requester holds req_valid.
- rst_n low at any time: asynchronous return to IDLE, in-flight op discarded, no rsp_valid generated.

## Timing
- Reset values: req_ready=1, pre_n=0, wl=0, wr_en=0, bl_data=0, sae=0, rsp_valid=0, rsp_rdata=0.
- Accept edge = E0. State PRE from E0.
- Read: PRE E0–E2, GAP E2–E3, WL E3–E6, SENSE E6–E7, rsp_valid high from E7 (PRE_CYC+1+WL_CYC+SAE_CYC clocks).
- Write: PRE E0–E2, GAP E2–E3, WL/wr_en E3–E6, rsp_valid high from E6 (PRE_CYC+1+WR_CYC).
- rsp_ready may be high before rsp_valid; then RESP lasts exactly one cycle and req_ready returns next cycle (min request spacing 8 clocks read, 7 write, defaults).
- All outputs registered or decoded from registered state only; no combinational path from req_*/rsp_ready to analog enables.

## Test plan
- Reset: assert rst_n=0 mid-cycle → all outputs at reset values asynchronously, before next clk edge.
- Write addr=5, wdata=0xA5, rsp_ready=1 → pre_n low 2 cycles, 1 gap, wl=16'h0020 with wr_en=1, bl_data=0xA5 for 3 cycles, rsp_valid at E6 for 1 cycle.
- Read addr=15, sa_out=0x3C driven during sae → wl=16'h8000 for 3 cycles, sae for 1 cycle after wl drops, rsp_rdata=0x3C with rsp_valid at E7.
- Response backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_valid, rsp_rdata stable, req_ready=0, pre_n=0; second req_valid held meanwhile is accepted only after rsp_ready.
- Reset mid-WL of a read (rst_n low at E4) → wl clears immediately, no rsp_valid after release; next request completes normally.
- Random back-to-back read/write stream (500 ops, rsp_ready random) → invariants never violated, read data matches scoreboard of last writes.

Source files
------------

// File: rtl/sram_access_ctrl.sv
// -----------------------------------------------------------------------------
// sram_access_ctrl
//
// Digital access sequencer for the mixed-signal SRAM array. Accepts one read
// or write request at a time and walks the array through an ordered,
// non-overlapping set of analog control phases:
//
//   IDLE -> PRE -> GAP -> WL -> (read: SENSE ->) RESP -> IDLE
//
// Every analog enable is decoded only from registered state (state_q, addr_q,
// we_q, wdata_q). There is no combinational path from req_* or rsp_ready to
// pre_n/wl/wr_en/bl_data/sae. This keeps the level-shifted gate drives glitch
// free with respect to the digital request port.
//
// Handshake semantics (both ports): a transfer happens on the rising clk edge
// where valid && ready are both high. The producer holds valid (and its
// payload) stable until that edge. req_ready is high only in IDLE, so a request
// presented while busy is simply not taken until the controller returns to
// IDLE. rsp_valid is held, with rsp_rdata stable, until rsp_ready is seen.
//
// Ports
//   clk        : array control clock, all state on the rising edge
//   rst_n      : asynchronous active-low reset, discards any in-flight op
//   req_valid  : request present
//   req_ready  : controller can accept (IDLE only)
//   req_we     : 1 = write, 0 = read
//   req_addr   : row address
//   req_wdata  : write data
//   rsp_valid  : operation complete (read data valid for reads)
//   rsp_ready  : consumer accepts the response
//   rsp_rdata  : captured read data (left unchanged by writes)
//   pre_n      : bitline precharge, active-low
//   wl         : one-hot wordline enables, 2**ADDR_W wide
//   wr_en      : write driver enable
//   bl_data    : write driver data, forced to 0 whenever wr_en is low
//   sae        : sense-amp enable
//   sa_out     : sense-amp outputs, valid while sae is high
//   dbg_state  : current FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module sram_access_ctrl #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int PRE_CYC = 2,
  parameter int WL_CYC  = 3,
  parameter int WR_CYC  = 3,
  parameter int SAE_CYC = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      pre_n,
  output logic [(1<<ADDR_W)-1:0]    wl,
  output logic                      wr_en,
  output logic [DATA_W-1:0]         bl_data,
  output logic                      sae,
  input  logic [DATA_W-1:0]         sa_out,
  output logic [2:0]                dbg_state
);

  localparam int ROWS = 1 << ADDR_W;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  localparam int MAX_CYC = max_of4(PRE_CYC, WL_CYC, WR_CYC, SAE_CYC);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // A zero-length phase would collapse break-before-make ordering.
  generate
    if (PRE_CYC < 1 || WL_CYC < 1 || WR_CYC < 1 || SAE_CYC < 1) begin : g_cfg_err
      $error("sram_access_ctrl: every *_CYC parameter must be at least 1");
    end
  endgenerate

  // The counter is loaded with (length - 1) on phase entry and the phase ends
  // on the cycle where it reads zero, so a phase lasts exactly its length.
  localparam logic [CNT_W-1:0] PRE_LD = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] WL_LD  = CNT_W'(WL_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LD  = CNT_W'(WR_CYC - 1);
  localparam logic [CNT_W-1:0] SAE_LD = CNT_W'(SAE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_GAP   = 3'd2,
    S_WL    = 3'd3,
    S_SENSE = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                cnt_last;
  logic                accept;
  logic                capture;

  assign cnt_last = (cnt_q == '0);
  assign accept   = (state_q == S_IDLE) && req_valid;
  assign capture  = (state_q == S_SENSE) && cnt_last;

  // ---------------------------------------------------------------------------
  // State and phase counter register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_PRE;
          cnt_d   = PRE_LD;
        end
      end
      S_PRE: begin
        if (cnt_last) begin
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        // Single dead cycle between precharge release and wordline rise.
        state_d = S_WL;
        cnt_d   = we_q ? WR_LD : WL_LD;
      end
      S_WL: begin
        if (cnt_last) begin
          if (we_q) begin
            state_d = S_RESP;
          end else begin
            state_d = S_SENSE;
            cnt_d   = SAE_LD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SENSE: begin
        if (cnt_last) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request latch and read-data capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Sense-amp data is sampled on the edge that ends the last SENSE cycle, so
  // the amplifiers have had the full SAE_CYC window to resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (capture) begin
      rdata_q <= sa_out;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode (registered state only)
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    pre_n     = 1'b1;
    wr_en     = 1'b0;
    sae       = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        pre_n     = 1'b0;
      end
      S_PRE: begin
        pre_n = 1'b0;
      end
      S_GAP: begin
        pre_n = 1'b1;
      end
      S_WL: begin
        wr_en = we_q;
      end
      S_SENSE: begin
        sae = 1'b1;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        pre_n     = 1'b0;
      end
      default: begin
        pre_n = 1'b0;
      end
    endcase
  end

  // One-hot wordline decode, only ever active in the WL state.
  always_comb begin
    wl = '0;
    for (int i = 0; i < ROWS; i++) begin
      wl[i] = (state_q == S_WL) && (addr_q == ADDR_W'(i));
    end
  end

  assign bl_data   = wr_en ? wdata_q : '0;
  assign rsp_rdata = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
module tb_sram_access_ctrl;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int ROWS   = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_rdata;
  logic              pre_n;
  logic [ROWS-1:0]   wl;
  logic              wr_en;
  logic [DATA_W-1:0] bl_data;
  logic              sae;
  logic [DATA_W-1:0] sa_out;
  logic [2:0]        dbg_state;

  sram_access_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .PRE_CYC(2), .WL_CYC(3), .WR_CYC(3), .SAE_CYC(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .pre_n(pre_n), .wl(wl), .wr_en(wr_en), .bl_data(bl_data), .sae(sae),
    .sa_out(sa_out), .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and checker
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural array: stores on wr_en, returns the last wordline row on sae
  // ---------------------------------------------------------------------------
  logic              use_model = 1'b0;
  logic [DATA_W-1:0] sa_drv = '0;
  logic [DATA_W-1:0] arr_mem [ROWS];
  int                last_row;

  function automatic int row_of(input logic [ROWS-1:0] v);
    for (int i = 0; i < ROWS; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (!use_model) begin
      for (int i = 0; i < ROWS; i++) arr_mem[i] <= '0;
      last_row <= 0;
    end else begin
      if (|wl) last_row <= row_of(wl);
      if (wr_en) arr_mem[row_of(wl)] <= bl_data;
    end
  end

  assign sa_out = use_model ? (sae ? arr_mem[last_row] : '0) : sa_drv;

  // ---------------------------------------------------------------------------
  // Per-cycle invariant monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("inv_wl_onehot", 32'($countones(wl) <= 1), 32'd1);
      chk("inv_pre_wl",    32'(!pre_n && (|wl)), 32'd0);
      chk("inv_sae_wl",    32'(sae && (|wl)), 32'd0);
      chk("inv_wr_sae",    32'(wr_en && sae), 32'd0);
      chk("inv_bl_zero",   32'(!wr_en && (bl_data != '0)), 32'd0);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed and random stimulus
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] sb_mem [ROWS];
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_exp;
  logic              r_early;
  int                n;

  initial begin
    // Reset values while rst_n is low from time zero
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_pre_n",     32'(pre_n), 32'd0);
    chk("rst_wl",        32'(wl), 32'd0);
    chk("rst_wr_en",     32'(wr_en), 32'd0);
    chk("rst_bl_data",   32'(bl_data), 32'd0);
    chk("rst_sae",       32'(sae), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Write addr 5, 0xA5, consumer already ready
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd5; req_wdata = 8'hA5;
    chk("wr_idle_ready", 32'(req_ready), 32'd1);
    step();  // E0
    req_valid = 1'b0; req_we = 1'b0; req_wdata = '0;
    chk("wr_pre0_pre_n", 32'(pre_n), 32'd0);
    chk("wr_pre0_ready", 32'(req_ready), 32'd0);
    step();  // E1
    chk("wr_pre1_pre_n", 32'(pre_n), 32'd0);
    chk("wr_pre1_wl",    32'(wl), 32'd0);
    step();  // E2
    chk("wr_gap_pre_n", 32'(pre_n), 32'd1);
    chk("wr_gap_wl",    32'(wl), 32'd0);
    chk("wr_gap_wr_en", 32'(wr_en), 32'd0);
    for (int i = 0; i < 3; i++) begin  // E3..E5
      step();
      chk("wr_wl_wl",      32'(wl), 32'h0020);
      chk("wr_wl_wr_en",   32'(wr_en), 32'd1);
      chk("wr_wl_bl_data", 32'(bl_data), 32'hA5);
      chk("wr_wl_pre_n",   32'(pre_n), 32'd1);
      chk("wr_wl_valid",   32'(rsp_valid), 32'd0);
    end
    step();  // E6
    chk("wr_resp_valid", 32'(rsp_valid), 32'd1);
    chk("wr_resp_wl",    32'(wl), 32'd0);
    chk("wr_resp_wr_en", 32'(wr_en), 32'd0);
    chk("wr_resp_bl",    32'(bl_data), 32'd0);
    chk("wr_resp_pre_n", 32'(pre_n), 32'd0);
    chk("wr_resp_rdata", 32'(rsp_rdata), 32'd0);
    step();  // E7
    chk("wr_done_valid", 32'(rsp_valid), 32'd0);
    chk("wr_done_ready", 32'(req_ready), 32'd1);

    // Read addr 15, sense amps present 0x3C during sae
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd15;
    step();  // E0
    req_valid = 1'b0;
    step(); step();  // E2
    chk("rd_gap_pre_n", 32'(pre_n), 32'd1);
    chk("rd_gap_wl",    32'(wl), 32'd0);
    for (int i = 0; i < 3; i++) begin  // E3..E5
      step();
      chk("rd_wl_wl",    32'(wl), 32'h8000);
      chk("rd_wl_wr_en", 32'(wr_en), 32'd0);
      chk("rd_wl_sae",   32'(sae), 32'd0);
    end
    step();  // E6
    chk("rd_sense_sae",   32'(sae), 32'd1);
    chk("rd_sense_wl",    32'(wl), 32'd0);
    chk("rd_sense_pre_n", 32'(pre_n), 32'd1);
    chk("rd_sense_valid", 32'(rsp_valid), 32'd0);
    sa_drv = 8'h3C;
    step();  // E7
    sa_drv = 8'h00;
    chk("rd_resp_valid", 32'(rsp_valid), 32'd1);
    chk("rd_resp_rdata", 32'(rsp_rdata), 32'h3C);
    chk("rd_resp_sae",   32'(sae), 32'd0);
    step();
    chk("rd_done_valid", 32'(rsp_valid), 32'd0);
    chk("rd_done_ready", 32'(req_ready), 32'd1);

    // Response backpressure with a second request waiting
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3;
    step();  // E0
    req_valid = 1'b0;
    sa_drv = 8'h5A;
    repeat (7) step();  // E7
    sa_drv = 8'h00;
    chk("bp_resp_valid", 32'(rsp_valid), 32'd1);
    chk("bp_resp_rdata", 32'(rsp_rdata), 32'h5A);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd3; req_wdata = 8'h77;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_rdata", 32'(rsp_rdata), 32'h5A);
      chk("bp_hold_ready", 32'(req_ready), 32'd0);
      chk("bp_hold_pre_n", 32'(pre_n), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_rel_valid", 32'(rsp_valid), 32'd0);
    chk("bp_rel_ready", 32'(req_ready), 32'd1);
    step();  // E0 of the held write
    req_valid = 1'b0; req_we = 1'b0; req_wdata = '0;
    chk("bp_acc_ready", 32'(req_ready), 32'd0);
    step(); step(); step();  // E3
    chk("bp_wr_wl", 32'(wl), 32'h0008);
    chk("bp_wr_bl", 32'(bl_data), 32'h77);
    step(); step(); step();  // E6
    chk("bp_wr_valid", 32'(rsp_valid), 32'd1);
    chk("bp_wr_rdata", 32'(rsp_rdata), 32'h5A);
    step();

    // Reset in the middle of a read wordline phase
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd9;
    step();  // E0
    req_valid = 1'b0;
    repeat (4) step();  // E4
    chk("mr_wl_before", 32'(wl), 32'h0200);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_async_wl",    32'(wl), 32'd0);
    chk("mr_async_pre_n", 32'(pre_n), 32'd0);
    chk("mr_async_ready", 32'(req_ready), 32'd1);
    chk("mr_async_valid", 32'(rsp_valid), 32'd0);
    chk("mr_async_rdata", 32'(rsp_rdata), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("mr_quiet_valid", 32'(rsp_valid), 32'd0);
    end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd5;
    step();  // E0
    req_valid = 1'b0;
    repeat (6) step();  // E6
    chk("mr_next_sae", 32'(sae), 32'd1);
    sa_drv = 8'hC3;
    step();  // E7
    sa_drv = 8'h00;
    chk("mr_next_valid", 32'(rsp_valid), 32'd1);
    chk("mr_next_rdata", 32'(rsp_rdata), 32'hC3);
    step();

    // Random read/write stream against the behavioural array
    for (int i = 0; i < ROWS; i++) sb_mem[i] = '0;
    use_model = 1'b1;
    rsp_ready = 1'b0;
    step();
    for (int op = 0; op < 500; op++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_addr  = 4'($urandom_range(0, ROWS - 1));
      r_data  = 8'($urandom_range(0, 255));
      r_early = 1'($urandom_range(0, 1));
      if (r_we) sb_mem[r_addr] = r_data;
      else      exp_q.push_back(sb_mem[r_addr]);
      req_valid = 1'b1; req_we = r_we; req_addr = r_addr; req_wdata = r_data;
      rsp_ready = r_early;
      step();
      req_valid = 1'b0;
      chk("rnd_accept", 32'(req_ready), 32'd0);
      n = 0;
      while (!rsp_valid && n < 20) begin
        step();
        n++;
      end
      chk("rnd_rsp_seen", 32'(rsp_valid), 32'd1);
      if (!r_early) begin
        repeat ($urandom_range(0, 3)) begin
          step();
          chk("rnd_rsp_hold", 32'(rsp_valid), 32'd1);
        end
      end
      if (!r_we) begin
        r_exp = exp_q.pop_front();
        chk("rnd_rdata", 32'(rsp_rdata), 32'(r_exp));
      end
      rsp_ready = 1'b1;
      step();
      chk("rnd_rsp_drop", 32'(rsp_valid), 32'd0);
      rsp_ready = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
